// File: rtl/vmicro16_mem_wbm_pkg.sv
// Shared types for the vmicro16 memory-stage Wishbone master.
// States are a plain 2-bit encoding so bus monitors can decode them directly.
package vmicro16_mem_wbm_pkg;

  localparam int WB_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    WBM_IDLE = 2'd0,
    WBM_STB  = 2'd1,
    WBM_WAIT = 2'd2,
    WBM_RESP = 2'd3
  } wbm_state_t;

  // A bus cycle is outstanding while strobing or waiting for the slave.
  function automatic logic wbm_busy(input wbm_state_t s);
    return (s == WBM_STB) || (s == WBM_WAIT);
  endfunction

endpackage

// File: rtl/vmicro16_mem_wbm_timeout.sv
// Bus-cycle watchdog: counts enabled cycles, flags the TIMEOUT-th one combinationally.
// No backpressure; TIMEOUT=0 never expires.
module vmicro16_wbm_timeout #(
  parameter int TIMEOUT      = 255,
  parameter int TIMEOUT_BITS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [TIMEOUT_BITS-1:0] r_cnt;
  logic                    w_hit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Expiry lands in the cycle that would bring the count to TIMEOUT.
  assign w_hit     = (r_cnt == TIMEOUT_BITS'(TIMEOUT - 1));
  assign o_expired = i_en && w_hit && (TIMEOUT != 0);

endmodule

// File: rtl/vmicro16_mem_wbm.sv
// Memory-stage Wishbone master: one LW/SW per pipelined cycle, 3 cycles minimum per op.
// req_ready only in IDLE; stall/wait cycles each add one cycle, timeout aborts with error.
module vmicro16_mem_wbm
  import vmicro16_mem_wbm_pkg::*;
#(
  parameter int DATA_WIDTH   = WB_DATA_WIDTH,
  parameter int RS_WIDTH     = 3,
  parameter int TIMEOUT      = 255,
  parameter int TIMEOUT_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [RS_WIDTH-1:0]   req_rd,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [RS_WIDTH-1:0]   resp_rd,
  output logic                  resp_we,
  output logic                  resp_err,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [DATA_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_stall_i,
  input  logic                  wb_err_i
);

  wbm_state_t            r_state;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [RS_WIDTH-1:0]   r_rd;
  logic                  r_cyc;
  logic                  r_stb;
  logic                  r_resp_valid;
  logic                  r_resp_we;
  logic                  r_resp_err;
  logic [DATA_WIDTH-1:0] r_resp_data;
  logic [RS_WIDTH-1:0]   r_resp_rd;

  logic w_busy;
  logic w_accept;
  logic w_expired;
  logic w_rsp;
  logic w_done;
  logic w_err;

  assign w_busy   = wbm_busy(r_state);
  assign w_accept = (r_state == WBM_IDLE) && req_valid;
  // A slave response counts only once the strobe has been accepted.
  assign w_rsp    = (wb_ack_i || wb_err_i) &&
                    (((r_state == WBM_STB) && !wb_stall_i) || (r_state == WBM_WAIT));
  assign w_done   = w_rsp || w_expired;
  assign w_err    = wb_err_i || !w_rsp;

  vmicro16_wbm_timeout #(
    .TIMEOUT      (TIMEOUT),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_accept),
    .i_en      (w_busy),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= WBM_IDLE;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rd         <= '0;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_we    <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_data  <= '0;
      r_resp_rd    <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        WBM_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_rd    <= req_rd;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_state <= WBM_STB;
          end
        end
        WBM_STB, WBM_WAIT: begin
          if (w_done) begin
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= w_err;
            r_resp_data  <= (w_err || r_we) ? '0 : wb_data_i;
            r_resp_rd    <= r_rd;
            r_resp_we    <= r_we;
            r_state      <= WBM_RESP;
          end else if ((r_state == WBM_STB) && !wb_stall_i) begin
            r_stb   <= 1'b0;
            r_state <= WBM_WAIT;
          end
        end
        WBM_RESP: r_state <= WBM_IDLE;
        default:  r_state <= WBM_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == WBM_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_rd    = r_resp_rd;
  assign resp_we    = r_resp_we;
  assign resp_err   = r_resp_err;
  assign wb_cyc_o   = r_cyc;
  assign wb_stb_o   = r_stb;
  assign wb_we_o    = r_we;
  assign wb_addr_o  = r_addr;
  assign wb_data_o  = r_wdata;

endmodule

// File: tb/tb_vmicro16_mem_wbm.sv
// Bench for vmicro16_mem_wbm: randomized transactions against a cycle-schedule model,
// plus a short-timeout instance for the watchdog path.
module tb_vmicro16_mem_wbm;

  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_we, req_ready;
  logic [15:0] req_addr, req_wdata;
  logic [2:0]  req_rd;
  logic        resp_valid, resp_we, resp_err;
  logic [15:0] resp_data;
  logic [2:0]  resp_rd;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [15:0] wb_addr_o, wb_data_o, wb_data_i;
  logic        wb_ack_i, wb_stall_i, wb_err_i;

  logic        t_req_valid, t_req_we, t_req_ready;
  logic [15:0] t_req_addr, t_req_wdata;
  logic [2:0]  t_req_rd;
  logic        t_resp_valid, t_resp_we, t_resp_err;
  logic [15:0] t_resp_data;
  logic [2:0]  t_resp_rd;
  logic        t_wb_cyc_o, t_wb_stb_o, t_wb_we_o;
  logic [15:0] t_wb_addr_o, t_wb_data_o, t_wb_data_i;
  logic        t_wb_ack_i, t_wb_stall_i, t_wb_err_i;

  vmicro16_mem_wbm #(.DATA_WIDTH(16), .RS_WIDTH(3), .TIMEOUT(TO), .TIMEOUT_BITS(8)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd), .resp_we(resp_we),
    .resp_err(resp_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o),
    .wb_data_o(wb_data_o), .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i),
    .wb_stall_i(wb_stall_i), .wb_err_i(wb_err_i)
  );

  vmicro16_mem_wbm #(.DATA_WIDTH(16), .RS_WIDTH(3), .TIMEOUT(4), .TIMEOUT_BITS(3)) u_dut_to (
    .clk(clk), .reset(reset),
    .req_valid(t_req_valid), .req_we(t_req_we), .req_addr(t_req_addr), .req_wdata(t_req_wdata),
    .req_rd(t_req_rd), .req_ready(t_req_ready),
    .resp_valid(t_resp_valid), .resp_data(t_resp_data), .resp_rd(t_resp_rd), .resp_we(t_resp_we),
    .resp_err(t_resp_err),
    .wb_cyc_o(t_wb_cyc_o), .wb_stb_o(t_wb_stb_o), .wb_we_o(t_wb_we_o), .wb_addr_o(t_wb_addr_o),
    .wb_data_o(t_wb_data_o), .wb_data_i(t_wb_data_i), .wb_ack_i(t_wb_ack_i),
    .wb_stall_i(t_wb_stall_i), .wb_err_i(t_wb_err_i)
  );

  int errors = 0;
  int checks = 0;

  // Expected DUT outputs for the current cycle, set by the driver from the model.
  logic        chk_en = 1'b0;
  logic        exp_ready, exp_cyc, exp_stb, exp_we_o, exp_rv, exp_rwe, exp_rerr;
  logic [15:0] exp_addr_o, exp_data_o, exp_rdata;
  logic [2:0]  exp_rrd;

  int cyc_cnt = 0;
  int acc_cycle = 0;
  int lat = -1;
  int stb_cnt = 0;
  logic [15:0] mem [0:65535];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
    end
  endtask

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (wb_stb_o && !wb_stall_i && wb_we_o) mem[wb_addr_o] = wb_data_o;
    if (wb_stb_o) stb_cnt++;
    if (resp_valid) lat = cyc_cnt - acc_cycle;
    if (chk_en) begin
      chk("req_ready", req_ready, exp_ready);
      chk("wb_cyc", wb_cyc_o, exp_cyc);
      chk("wb_stb", wb_stb_o, exp_stb);
      if (exp_stb) begin
        chk("wb_we", wb_we_o, exp_we_o);
        chk("wb_addr", wb_addr_o, exp_addr_o);
        chk("wb_data", wb_data_o, exp_data_o);
      end
      chk("resp_valid", resp_valid, exp_rv);
      chk("resp_data", resp_data, exp_rdata);
      chk("resp_rd", resp_rd, exp_rrd);
      chk("resp_we", resp_we, exp_rwe);
      chk("resp_err", resp_err, exp_rerr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      req_valid  = 1'b0;
      req_addr   = 16'($urandom);
      wb_ack_i   = 1'($urandom);
      wb_err_i   = 1'($urandom);
      wb_stall_i = 1'($urandom);
      wb_data_i  = 16'($urandom);
      exp_ready = 1'b1; exp_cyc = 1'b0; exp_stb = 1'b0; exp_rv = 1'b0;
    end
  endtask

  // kind: 0 ack, 1 err, 2 ack+err, 3 silent. Slave stalls s cycles, responds l cycles after acceptance.
  task automatic txn(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                     input logic [2:0] rd, input int s, input int l, input int kind,
                     input logic [15:0] rdat);
    int   r, d, nstb;
    logic tmo;
    r    = s + l;
    tmo  = (kind == 3) || (r >= TO);
    d    = tmo ? TO : r + 1;
    nstb = (s + 1 < d) ? s + 1 : d;
    step();
    acc_cycle = cyc_cnt;
    stb_cnt   = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_rd = rd;
    wb_ack_i = 1'($urandom); wb_err_i = 1'($urandom);
    wb_stall_i = 1'($urandom); wb_data_i = 16'($urandom);
    exp_ready = 1'b1; exp_cyc = 1'b0; exp_stb = 1'b0; exp_rv = 1'b0;
    for (int k = 1; k <= d; k++) begin
      step();
      req_valid = 1'($urandom); req_we = 1'($urandom); req_addr = 16'($urandom);
      req_wdata = 16'($urandom); req_rd = 3'($urandom);
      wb_stall_i = (k <= s) ? 1'b1 : (k == s + 1) ? 1'b0 : 1'($urandom);
      wb_ack_i   = !tmo && (k == r + 1) && (kind != 1);
      wb_err_i   = !tmo && (k == r + 1) && (kind != 0);
      wb_data_i  = (k == r + 1) ? rdat : 16'($urandom);
      exp_ready = 1'b0; exp_cyc = 1'b1; exp_stb = (k <= nstb); exp_rv = 1'b0;
      exp_we_o = we; exp_addr_o = addr; exp_data_o = wd;
    end
    step();
    req_valid = 1'($urandom); req_addr = 16'($urandom);
    wb_ack_i = 1'($urandom); wb_err_i = 1'($urandom); wb_data_i = 16'($urandom);
    exp_ready = 1'b0; exp_cyc = 1'b0; exp_stb = 1'b0; exp_rv = 1'b1;
    exp_rerr  = tmo || (kind != 0);
    exp_rdata = (exp_rerr || we) ? 16'h0000 : rdat;
    exp_rrd   = rd;
    exp_rwe   = we;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rv_at;
    logic rv_err, c4, c5;
    logic [15:0] rv_data;
    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_rd = '0;
    wb_data_i = '0; wb_ack_i = 1'b0; wb_stall_i = 1'b0; wb_err_i = 1'b0;
    t_req_valid = 1'b0; t_req_we = 1'b0; t_req_addr = '0; t_req_wdata = '0; t_req_rd = '0;
    t_wb_data_i = '0; t_wb_ack_i = 1'b0; t_wb_stall_i = 1'b0; t_wb_err_i = 1'b0;
    exp_ready = 1'b1; exp_cyc = 1'b0; exp_stb = 1'b0; exp_we_o = 1'b0; exp_rv = 1'b0;
    exp_addr_o = '0; exp_data_o = '0; exp_rdata = '0; exp_rrd = '0; exp_rwe = 1'b0; exp_rerr = 1'b0;

    // Reset state
    step(); step();
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_we", wb_we_o, 0);
    chk("rst_addr", wb_addr_o, 0);
    chk("rst_data", wb_data_o, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_rd", resp_rd, 0);
    chk("rst_resp_err", resp_err, 0);
    step();
    reset = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // Zero-wait store
    txn(1'b1, 16'h0010, 16'hBEEF, 3'd0, 0, 0, 0, 16'h0000);
    idle(1);
    chk("sw_latency", lat, 2);
    chk("sw_mem", mem[16'h0010], 16'hBEEF);
    chk("sw_resp_we", resp_we, 1);
    chk("sw_resp_err", resp_err, 0);

    // Load with 2 stall cycles and ack 3 cycles after acceptance
    txn(1'b0, 16'h0200, 16'h7777, 3'd5, 2, 3, 0, 16'h1234);
    idle(1);
    chk("ld_latency", lat, 7);
    chk("ld_stb_cycles", stb_cnt, 3);
    chk("ld_resp_data", resp_data, 16'h1234);
    chk("ld_resp_rd", resp_rd, 5);

    // ack and err together
    txn(1'b0, 16'h0300, 16'h0000, 3'd2, 0, 1, 2, 16'hFFFF);
    idle(1);
    chk("both_resp_err", resp_err, 1);
    chk("both_resp_data", resp_data, 0);

    // Back-to-back, three ops with no idle gap
    txn(1'b0, 16'h0400, 16'h0000, 3'd1, 0, 0, 0, 16'hAAA1);
    txn(1'b1, 16'h0401, 16'h5555, 3'd2, 0, 0, 0, 16'hAAA2);
    txn(1'b0, 16'h0402, 16'h0000, 3'd3, 0, 0, 0, 16'hAAA3);
    idle(1);
    chk("b2b_latency", lat, 2);
    chk("b2b_resp_data", resp_data, 16'hAAA3);
    chk("b2b_resp_rd", resp_rd, 3);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      int s, l, kind;
      s = int'($urandom_range(0, 3));
      l = int'($urandom_range(0, 4));
      if ($urandom_range(0, 7) == 0) begin
        s = int'($urandom_range(0, 20));
        l = int'($urandom_range(0, 20));
      end
      case ($urandom_range(0, 9))
        0:       kind = 1;
        1:       kind = 2;
        2:       kind = 3;
        default: kind = 0;
      endcase
      txn(1'($urandom), 16'($urandom), 16'($urandom), 3'($urandom), s, l, kind, 16'($urandom));
      idle(int'($urandom_range(0, 2)));
    end

    // Reset while waiting for the slave
    chk_en = 1'b0;
    step();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0500; req_rd = 3'd3;
    wb_stall_i = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    step();
    req_valid = 1'b0;
    step();
    @(negedge clk);
    chk("mid_wait_cyc", wb_cyc_o, 1);
    chk("mid_wait_stb", wb_stb_o, 0);
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    wb_ack_i = 1'b1; wb_data_i = 16'hDEAD;
    @(negedge clk);
    chk("mid_rst_cyc", wb_cyc_o, 0);
    chk("mid_rst_resp_valid", resp_valid, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    step();
    @(negedge clk);
    chk("spur_resp_valid", resp_valid, 0);
    step();
    wb_ack_i = 1'b0;
    @(negedge clk);
    chk("spur_resp_valid2", resp_valid, 0);
    chk("spur_resp_data", resp_data, 0);
    exp_rdata = '0; exp_rrd = '0; exp_rwe = 1'b0; exp_rerr = 1'b0;
    exp_ready = 1'b1; exp_cyc = 1'b0; exp_stb = 1'b0; exp_rv = 1'b0;
    chk_en = 1'b1;
    txn(1'b0, 16'h0600, 16'h0000, 3'd4, 1, 1, 0, 16'h4242);
    idle(2);

    // Watchdog path on the TIMEOUT=4 instance with a silent slave
    chk_en = 1'b0;
    step();
    t_req_valid = 1'b1; t_req_we = 1'b0; t_req_addr = 16'h0700; t_req_rd = 3'd6;
    rv_at = -1; rv_err = 1'b0; c4 = 1'b0; c5 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      t_req_valid = 1'b0;
      @(negedge clk);
      if (t_resp_valid && rv_at < 0) begin
        rv_at = k;
        rv_err = t_resp_err;
      end
      if (k == 4) c4 = t_wb_cyc_o;
      if (k == 5) c5 = t_wb_cyc_o;
    end
    chk("to_resp_cycle", rv_at, 5);
    chk("to_resp_err", rv_err, 1);
    chk("to_cyc_last_wait", c4, 1);
    chk("to_cyc_dropped", c5, 0);
    chk("to_req_ready", t_req_ready, 1);

    step();
    t_req_valid = 1'b1; t_req_we = 1'b0; t_req_addr = 16'h0701; t_req_rd = 3'd1;
    rv_at = -1; rv_err = 1'b1; rv_data = '0;
    for (int k = 1; k <= 6; k++) begin
      step();
      t_req_valid = 1'b0;
      t_wb_ack_i  = (k == 1);
      t_wb_data_i = 16'h5A5A;
      @(negedge clk);
      if (t_resp_valid && rv_at < 0) begin
        rv_at = k;
        rv_err = t_resp_err;
        rv_data = t_resp_data;
      end
    end
    chk("to_next_cycle", rv_at, 2);
    chk("to_next_err", rv_err, 0);
    chk("to_next_data", rv_data, 16'h5A5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
